difficulty_ramp: RTL and testbench

//  Upstream control stage for the timer cluster: produces the shared decrement word dec[30:0].
//  The timer cluster subtracts dec from every timer period, so the game speeds up as the level rises.
//  The level advances on kill count or on elapsed slow ticks, whichever threshold is reached first.

---
 rtl/difficulty_ramp.sv | 105 ++++++++++
 tb/tb_difficulty_ramp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/difficulty_ramp.sv
// Level/decrement controller for the timer cluster: advances the level on kill or
// tick thresholds and publishes a saturated decrement word one cycle behind level.
module difficulty_ramp #(
  parameter int unsigned DEC_STEP        = 1_000_000,
  parameter int unsigned DEC_MAX         = 90_000_000,
  parameter int unsigned KILLS_PER_LEVEL = 10,
  parameter int unsigned TICKS_PER_LEVEL = 30,
  parameter int unsigned MAX_LEVEL       = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        kill_pulse,
  input  logic        tick_pulse,
  output logic [30:0] dec,
  output logic [7:0]  level,
  output logic        level_up,
  output logic        running
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_MAXED  = 2'd3;

  localparam int unsigned KW = $clog2(KILLS_PER_LEVEL + 1);
  localparam int unsigned TW = $clog2(TICKS_PER_LEVEL + 1);

  logic [1:0]    state;
  logic [KW-1:0] kill_cnt;
  logic [TW-1:0] tick_cnt;
  logic [KW:0]   kill_sum;
  logic [TW:0]   tick_sum;
  logic          level_hit;
  logic [7:0]    level_next;
  logic [39:0]   dec_prod;
  logic [30:0]   dec_sat;

  // The triggering pulse is counted before the threshold compare.
  assign kill_sum   = {1'b0, kill_cnt} + (KW + 1)'(kill_pulse);
  assign tick_sum   = {1'b0, tick_cnt} + (TW + 1)'(tick_pulse);
  assign level_hit  = (kill_sum >= (KW + 1)'(KILLS_PER_LEVEL)) ||
                      (tick_sum >= (TW + 1)'(TICKS_PER_LEVEL));
  assign level_next = level + 8'd1;

  assign dec_prod = 40'(level) * 40'(DEC_STEP);
  assign dec_sat  = (dec_prod > 40'(DEC_MAX)) ? 31'(DEC_MAX) : dec_prod[30:0];

  assign running = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      level    <= '0;
      level_up <= 1'b0;
      kill_cnt <= '0;
      tick_cnt <= '0;
      dec      <= '0;
    end else begin
      level_up <= 1'b0;
      dec      <= dec_sat;
      if (stop && state != S_IDLE) begin
        state    <= S_IDLE;
        level    <= '0;
        kill_cnt <= '0;
        tick_cnt <= '0;
      end else if (start) begin
        state    <= (MAX_LEVEL == 1) ? S_MAXED : S_RUN;
        level    <= 8'd1;
        kill_cnt <= '0;
        tick_cnt <= '0;
      end else begin
        case (state)
          S_RUN: begin
            if (pause) begin
              state <= S_PAUSED;
            end else if (level_hit) begin
              level    <= level_next;
              level_up <= 1'b1;
              kill_cnt <= '0;
              tick_cnt <= '0;
              if (level_next == 8'(MAX_LEVEL))
                state <= S_MAXED;
            end else begin
              kill_cnt <= kill_sum[KW-1:0];
              tick_cnt <= tick_sum[TW-1:0];
            end
          end
          S_PAUSED: begin
            if (!pause)
              state <= S_RUN;
          end
          S_MAXED: begin
            kill_cnt <= '0;
            tick_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_difficulty_ramp.sv
// Scoreboard bench for difficulty_ramp: expected levels are queued per level_up,
// monitors pop and compare on each pulse; directed checks cover the remaining outputs.
module tb_difficulty_ramp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0, kill_pulse = 1'b0, tick_pulse = 1'b0;
  logic [30:0] dec;
  logic [7:0]  level;
  logic        level_up, running;

  logic start5 = 1'b0, stop5 = 1'b0, pause5 = 1'b0, kill5 = 1'b0, tick5 = 1'b0;
  logic [30:0] dec5;
  logic [7:0]  level5;
  logic        level_up5, running5;

  int checks = 0;
  int errors = 0;
  int lu5_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp5_q[$];

  always #5 clk = ~clk;

  difficulty_ramp dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .kill_pulse(kill_pulse), .tick_pulse(tick_pulse),
    .dec(dec), .level(level), .level_up(level_up), .running(running)
  );

  difficulty_ramp #(
    .DEC_STEP(30_000_000), .DEC_MAX(90_000_000), .KILLS_PER_LEVEL(10),
    .TICKS_PER_LEVEL(30), .MAX_LEVEL(5)
  ) dut5 (
    .clk(clk), .rst(rst), .start(start5), .stop(stop5), .pause(pause5),
    .kill_pulse(kill5), .tick_pulse(tick5),
    .dec(dec5), .level(level5), .level_up(level_up5), .running(running5)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: one pop per level_up pulse.
  always @(negedge clk) begin
    if (level_up === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_level_up: got level %0d expected no pulse", level);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (level !== e) begin
          errors++;
          $display("FAIL sb_level: got %0d expected %0d", level, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (level_up5 === 1'b1) begin
      lu5_count++;
      checks++;
      if (exp5_q.size() == 0) begin
        errors++;
        $display("FAIL sb5_unexpected_level_up: got level %0d expected no pulse", level5);
      end else begin
        logic [7:0] e;
        e = exp5_q.pop_front();
        if (level5 !== e) begin
          errors++;
          $display("FAIL sb5_level: got %0d expected %0d", level5, e);
        end
      end
    end
  end

  task automatic cyc(input logic k, input logic t);
    kill_pulse = k;
    tick_pulse = t;
    @(posedge clk); #1;
    kill_pulse = 1'b0;
    tick_pulse = 1'b0;
  endtask

  task automatic kills(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cyc5(input logic k, input logic t);
    kill5 = k;
    tick5 = t;
    @(posedge clk); #1;
    kill5 = 1'b0;
    tick5 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_dec", dec, 0);
    chk("rst_running", running, 0);
    chk("rst_level_up", level_up, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1) start
    do_start();
    chk("t1_level", level, 1);
    chk("t1_running", running, 1);
    chk("t1_level_up", level_up, 0);
    cyc(1'b0, 1'b0);
    chk("t1_dec", dec, 1_000_000);

    // 2) ten kills
    kills(9);
    chk("t2_level_before", level, 1);
    exp_q.push_back(8'd2);
    cyc(1'b1, 1'b0);
    chk("t2_level", level, 2);
    chk("t2_level_up", level_up, 1);
    chk("t2_kill_cnt", dut.kill_cnt, 0);
    chk("t2_tick_cnt", dut.tick_cnt, 0);
    cyc(1'b0, 1'b0);
    chk("t2_level_up_width", level_up, 0);
    chk("t2_dec", dec, 2_000_000);

    // 3) coincident thresholds
    kills(9);
    for (int i = 0; i < 29; i++) cyc(1'b0, 1'b1);
    chk("t3_level_before", level, 2);
    exp_q.push_back(8'd3);
    cyc(1'b1, 1'b1);
    chk("t3_level", level, 3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t3_level_single", level, 3);
    chk("t3_dec", dec, 3_000_000);

    // 4) pause
    pause = 1'b1;
    cyc(1'b0, 1'b0);
    kills(50);
    pause = 1'b0;
    cyc(1'b0, 1'b0);
    chk("t4_level_paused", level, 3);
    chk("t4_running", running, 1);
    kills(9);
    chk("t4_level_9", level, 3);
    exp_q.push_back(8'd4);
    cyc(1'b1, 1'b0);
    chk("t4_level", level, 4);

    // 6) stop + start together
    stop = 1'b1;
    start = 1'b1;
    cyc(1'b0, 1'b0);
    stop = 1'b0;
    start = 1'b0;
    chk("t6_level", level, 0);
    chk("t6_running", running, 0);
    cyc(1'b0, 1'b0);
    chk("t6_dec", dec, 0);
    kills(12);
    chk("t6_idle_ignores", level, 0);

    // async reset mid-count
    do_start();
    kills(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_level", level, 0);
    chk("t6_arst_dec", dec, 0);
    chk("t6_arst_running", running, 0);
    chk("t6_arst_level_up", level_up, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_start();
    chk("t6_restart_level", level, 1);
    kills(9);
    chk("t6_restart_9", level, 1);
    exp_q.push_back(8'd2);
    cyc(1'b1, 1'b0);
    chk("t6_restart_lu", level, 2);

    // 5) saturation and MAXED on the small-range instance
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    chk("t5_level1", level5, 1);
    for (int lv = 2; lv <= 5; lv++) begin
      for (int i = 0; i < 9; i++) cyc5(1'b1, 1'b0);
      exp5_q.push_back(8'(lv));
      cyc5(1'b1, 1'b0);
      chk("t5_level", level5, 40'(lv));
      if (lv == 3) begin
        chk("t5_dec_l2", dec5, 60_000_000);
        cyc5(1'b0, 1'b0);
        chk("t5_dec_l3", dec5, 90_000_000);
      end
    end
    cyc5(1'b0, 1'b0);
    chk("t5_dec_l5", dec5, 90_000_000);
    for (int i = 0; i < 40; i++) cyc5(1'b1, 1'b1);
    chk("t5_maxed_level", level5, 5);
    chk("t5_maxed_dec", dec5, 90_000_000);
    chk("t5_maxed_running", running5, 1);
    chk("t5_maxed_kill_cnt", dut5.kill_cnt, 0);

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb5_drained", exp5_q.size(), 0);
    chk("t5_level_up_count", lu5_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
